pgm_ddram_rd_bridge: RTL and testbench
======================================

Name: pgm_ddram_rd_bridge

Overview:
- Sits directly upstream of the PGM video renderer's graphics-ROM port.
- Converts the renderer's single-word, level-held read requests (rd/addr, answered by busy/dout/dout_ready) into MiSTer DDRAM Avalon burst reads.
- Holds the last fetched burst in a one-line cache, so sequential sprite/tile reads within a burst are served without a DDRAM round trip.

Parameters:
- BURST, 4, 64-bit words per DDRAM burst and cache line; power of two, 1..16.
- LBW, 2, log2(BURST); for BURST=1, LBW=0 and the tag is the full address.

Ports:
- clk  in  1  system/video clock; the only clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- inval  in  1  one-cycle pulse; clears the cache valid bit (issued at vblank/ROM reload).
- vid_rd  in  1  read request from renderer; held until dout_ready is seen.
- vid_addr  in  29  64-bit word address, sampled when a request is accepted.
- vid_busy  out  1  bridge cannot accept a new request.
- vid_dout  out  64  read data; valid in the dout_ready cycle and held until the next delivery.
- vid_dout_ready  out  1  one-cycle data-valid pulse.
- DDRAM_ADDR  out  29  burst base address (aligned to BURST).
- DDRAM_BURSTCNT  out  8  burst length.
- DDRAM_RD  out  1  Avalon read; held while DDRAM_BUSY=1.
- DDRAM_BUSY  in  1  Avalon waitrequest.
- DDRAM_DOUT  in  64  returned beat.
- DDRAM_DOUT_READY  in  1  beat valid.

Behaviour:
- Reset (reset=0 at clk edge):
  - state=IDLE, valid=0.
  - All outputs 0: vid_busy, vid_dout_ready, vid_dout, DDRAM_RD, DDRAM_ADDR, DDRAM_BURSTCNT.
- Registers:
  - tag[28:LBW] and valid.
  - line[0:BURST-1] x 64 bits.
  - beat counter [LBW:0].
  - latched request address.
- State IDLE: vid_busy=0. If vid_rd=1, latch vid_addr and set vid_busy=1 next cycle.
  - Hit (valid and vid_addr[28:LBW]==tag) -> HIT.
  - Miss -> REQ.
- State HIT:
  - vid_dout <= line[addr[LBW-1:0]]; vid_dout_ready pulses 1 cycle -> DONE.
  - Hit latency: request sampled at edge N, dout_ready high in cycle N+2.
- State REQ:
  - Drive DDRAM_RD=1, DDRAM_ADDR={addr[28:LBW], LBW'b0}, DDRAM_BURSTCNT=BURST.
  - Hold all three stable while DDRAM_BUSY=1.
  - At the first edge with DDRAM_BUSY=0: DDRAM_RD<=0, beat counter=0, -> FILL.
- State FILL:
  - Each DDRAM_DOUT_READY writes line[beat] and increments beat.
  - On the last beat (beat==BURST-1): tag<=addr[28:LBW], valid<=1, vid_dout<=requested word (from DDRAM_DOUT when it is the last beat itself), vid_dout_ready pulse -> DONE.
  - Data is delivered only after the full burst; no early forwarding.
- State DONE:
  - vid_busy stays 1 until vid_rd=0, then -> IDLE.
  - This prevents the still-high vid_rd in the cycle after dout_ready from being taken as a second request.
- inval:
  - In IDLE/HIT/DONE: valid<=0 next cycle. A HIT already in progress still delivers its latched data.
  - In REQ/FILL: marks the fill as stale; data is still delivered to the renderer, but valid stays 0 at the end of the fill.
  - inval coincident with the final FILL beat: valid ends 0.
- Stray DDRAM_DOUT_READY:
  - Outside FILL it is ignored; it never writes the line and never raises vid_dout_ready.
- Reset mid-burst:
  - The bridge returns to IDLE immediately. DDRAM controller reset is shared with this block; outstanding beats are not tracked after reset.
- Widths: DDRAM_BURSTCNT = BURST zero-extended to 8 bits; address arithmetic is 29-bit, with no carry past bit 28.
- vid_dout_ready is never high for 2 consecutive cycles. At most one request is outstanding.

Optional Feature:
- Macro: PGM_DDRAM_CACHE_EN.
- Defined: cache and BURST-beat bursts as described above.
- Undefined:
  - No tag/valid/line storage; HIT is never entered; inval is ignored.
  - Every request issues DDRAM_BURSTCNT=1 at DDRAM_ADDR=vid_addr (unaligned).
  - The single beat goes directly to vid_dout with a dout_ready pulse the cycle after DDRAM_DOUT_READY -> DONE.

Test Plan:
- Miss, BURST=4: rd addr 0x0000105, DDRAM_BUSY=1 for 3 cycles -> DDRAM_RD held 4 cycles at ADDR 0x0000104, BURSTCNT=4; beats D0..D3 return -> vid_dout=D1, one dout_ready pulse after D3; busy drops only after rd=0.
- Hit: after the above, rd 0x0000107 -> no DDRAM_RD, vid_dout=D3, dout_ready 2 cycles after rd sampled; rd 0x0000108 -> miss at 0x0000108.
- Held rd: renderer keeps rd=1 one cycle after dout_ready, then re-raises rd with addr 0x0000106 -> exactly one delivery per rd assertion; second delivery is a hit with data D2.
- inval: pulse inval during FILL -> first delivery correct; repeat of the same address -> new DDRAM burst issued.
- Reset (reset=0) asserted in FILL after 2 beats -> all outputs 0, state IDLE, next request to the same line misses.
- PGM_DDRAM_CACHE_EN undefined: rd 0x0000105 twice -> two DDRAM reads at 0x0000105 with BURSTCNT=1; inval has no effect.

Source files
------------

// File: rtl/pgm_ddram_rd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : pgm_ddram_rd_bridge
// Brief    : Renderer graphics-ROM reads to MiSTer DDRAM Avalon bursts, with an
//            optional one-line burst cache (macro PGM_DDRAM_CACHE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module pgm_ddram_rd_bridge #(
    parameter int BURST = 4,
    parameter int LBW   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inval,
    input  logic        vid_rd,
    input  logic [28:0] vid_addr,
    output logic        vid_busy,
    output logic [63:0] vid_dout,
    output logic        vid_dout_ready,
    output logic [28:0] DDRAM_ADDR,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic        DDRAM_RD,
    input  logic        DDRAM_BUSY,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HIT  = 3'd1,
        REQ  = 3'd2,
        FILL = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state;
    state_t state_next;
    logic   hit_now;
    logic   last_beat;

    assign vid_busy = (state != IDLE);
    assign DDRAM_RD = (state == REQ);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (vid_rd) state_next = hit_now ? HIT : REQ;
            HIT:     state_next = DONE;
            REQ:     if (!DDRAM_BUSY) state_next = FILL;
            FILL:    if (DDRAM_DOUT_READY && last_beat) state_next = DONE;
            DONE:    if (!vid_rd) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef PGM_DDRAM_CACHE_EN
    localparam int IW = (LBW > 0) ? LBW : 1;
    localparam int BW = LBW + 1;

    logic [28:LBW]  tag;
    logic           valid;
    logic           stale;
    logic [63:0]    line [BURST];
    logic [BW-1:0]  beat;
    logic [28:0]    addr_q;
    logic [IW-1:0]  req_idx;
    logic [IW-1:0]  beat_idx;

    assign req_idx   = (LBW > 0) ? addr_q[IW-1:0] : '0;
    assign beat_idx  = (LBW > 0) ? beat[IW-1:0] : '0;
    assign hit_now   = valid && (vid_addr[28:LBW] == tag);
    assign last_beat = (beat == BW'(BURST - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            tag            <= '0;
            valid          <= 1'b0;
            stale          <= 1'b0;
            beat           <= '0;
            addr_q         <= '0;
            vid_dout       <= '0;
            vid_dout_ready <= 1'b0;
            DDRAM_ADDR     <= '0;
            DDRAM_BURSTCNT <= '0;
        end else begin
            vid_dout_ready <= 1'b0;
            // An inval while a burst is in flight must not let that burst become valid.
            if (inval && (state == IDLE || state == HIT || state == DONE)) valid <= 1'b0;
            if (inval) stale <= 1'b1;
            case (state)
                IDLE: if (vid_rd) begin
                    addr_q <= vid_addr;
                    stale  <= 1'b0;
                    if (!hit_now) begin
                        DDRAM_ADDR     <= vid_addr & ~29'(BURST - 1);
                        DDRAM_BURSTCNT <= 8'(BURST);
                    end
                end
                HIT: begin
                    vid_dout       <= line[req_idx];
                    vid_dout_ready <= 1'b1;
                end
                REQ: if (!DDRAM_BUSY) beat <= '0;
                FILL: if (DDRAM_DOUT_READY) begin
                    line[beat_idx] <= DDRAM_DOUT;
                    beat           <= beat + BW'(1);
                    if (last_beat) begin
                        tag            <= addr_q[28:LBW];
                        valid          <= !(stale || inval);
                        vid_dout       <= (req_idx == beat_idx) ? DDRAM_DOUT : line[req_idx];
                        vid_dout_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    logic unused_inval;

    assign hit_now      = 1'b0;
    assign last_beat    = 1'b1;
    assign unused_inval = &{1'b0, inval};

    always_ff @(posedge clk) begin
        if (!reset) begin
            vid_dout       <= '0;
            vid_dout_ready <= 1'b0;
            DDRAM_ADDR     <= '0;
            DDRAM_BURSTCNT <= '0;
        end else begin
            vid_dout_ready <= 1'b0;
            if (state == IDLE && vid_rd) begin
                DDRAM_ADDR     <= vid_addr;
                DDRAM_BURSTCNT <= 8'd1;
            end
            if (state == FILL && DDRAM_DOUT_READY) begin
                vid_dout       <= DDRAM_DOUT;
                vid_dout_ready <= 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pgm_ddram_rd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_pgm_ddram_rd_bridge
// Brief    : Directed self-checking bench for pgm_ddram_rd_bridge (both builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pgm_ddram_rd_bridge;

`ifdef PGM_DDRAM_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    localparam int NBEAT = CACHE ? 4 : 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        inval = 1'b0;
    logic        vid_rd = 1'b0;
    logic [28:0] vid_addr = '0;
    logic        vid_busy;
    logic [63:0] vid_dout;
    logic        vid_dout_ready;
    logic [28:0] DDRAM_ADDR;
    logic [7:0]  DDRAM_BURSTCNT;
    logic        DDRAM_RD;
    logic        DDRAM_BUSY = 1'b0;
    logic [63:0] DDRAM_DOUT = '0;
    logic        DDRAM_DOUT_READY = 1'b0;

    int checks = 0;
    int failures = 0;
    int gen = 0;

    int          rd_cyc, pulses, lat, g_save;
    logic [28:0] s_addr;
    logic [7:0]  s_cnt;
    logic [63:0] got;
    logic        busy_hold, busy_after, tmo;

    pgm_ddram_rd_bridge dut (
        .clk(clk), .reset(reset), .inval(inval), .vid_rd(vid_rd), .vid_addr(vid_addr),
        .vid_busy(vid_busy), .vid_dout(vid_dout), .vid_dout_ready(vid_dout_ready),
        .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_RD(DDRAM_RD),
        .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mkdata(input int g, input logic [28:0] a);
        return {16'hC0DE, 16'(g), 3'b000, a};
    endfunction

    function automatic logic [28:0] line_base(input logic [28:0] a);
        return CACHE ? (a & ~29'h3) : a;
    endfunction

    // One renderer read against a DDRAM model; returns observations only.
    task automatic run_read(input logic [28:0] a, input int busy_cyc, input int hold,
                            input int inval_beat,
                            output int o_rd, output logic [28:0] o_addr, output logic [7:0] o_cnt,
                            output logic [63:0] o_got, output int o_pulses, output int o_lat,
                            output logic o_bhold, output logic o_bafter, output logic o_tmo);
        int  beat = 0;
        int  drop_at = -1;
        bit  fill = 0;
        gen++;
        o_rd = 0; o_addr = '0; o_cnt = '0; o_got = '0; o_pulses = 0; o_lat = -1;
        o_bhold = 1'b0; o_bafter = 1'b1; o_tmo = 1'b1;
        vid_addr = a;
        vid_rd   = 1'b1;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(posedge clk); #1;
            DDRAM_DOUT_READY = 1'b0;
            inval = 1'b0;
            if (DDRAM_RD) begin
                o_rd++;
                o_addr = DDRAM_ADDR;
                o_cnt  = DDRAM_BURSTCNT;
                DDRAM_BUSY = (o_rd <= busy_cyc);
                fill = 1;
                beat = 0;
            end else if (fill && beat < int'(o_cnt)) begin
                DDRAM_DOUT_READY = 1'b1;
                DDRAM_DOUT = mkdata(gen, o_addr + 29'(beat));
                if (beat == inval_beat) inval = 1'b1;
                beat++;
            end
            if (vid_dout_ready) begin
                o_pulses++;
                o_got = vid_dout;
                if (o_lat < 0) o_lat = cyc;
            end
            if (o_lat >= 0 && drop_at < 0 && cyc == o_lat + hold) begin
                o_bhold = vid_busy;
                vid_rd  = 1'b0;
                drop_at = cyc;
            end else if (drop_at >= 0 && cyc == drop_at + 1) begin
                o_bafter = vid_busy;
            end else if (drop_at >= 0 && cyc >= drop_at + 4) begin
                o_tmo = 1'b0;
                break;
            end
        end
        vid_rd = 1'b0; DDRAM_DOUT_READY = 1'b0; inval = 1'b0; DDRAM_BUSY = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (vid_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", vid_busy); end
        checks++; if (vid_dout_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", vid_dout_ready); end
        checks++; if (vid_dout !== 64'd0) begin failures++; $display("FAIL reset_dout got=%h exp=0", vid_dout); end
        checks++; if (DDRAM_RD !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", DDRAM_RD); end
        checks++; if (DDRAM_ADDR !== 29'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", DDRAM_ADDR); end
        checks++; if (DDRAM_BURSTCNT !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", DDRAM_BURSTCNT); end
        reset = 1'b1;
    endtask

    task automatic test_miss();
        run_read(29'h105, 3, 0, -1, rd_cyc, s_addr, s_cnt, got, pulses, lat, busy_hold, busy_after, tmo);
        checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL miss_timeout got=%b exp=0", tmo); end
        checks++; if (rd_cyc !== 4) begin failures++; $display("FAIL miss_rd_cycles got=%0d exp=4", rd_cyc); end
        checks++; if (s_addr !== line_base(29'h105)) begin failures++; $display("FAIL miss_addr got=%h exp=%h", s_addr, line_base(29'h105)); end
        checks++; if (s_cnt !== 8'(NBEAT)) begin failures++; $display("FAIL miss_burstcnt got=%0d exp=%0d", s_cnt, NBEAT); end
        checks++; if (got !== mkdata(gen, 29'h105)) begin failures++; $display("FAIL miss_data got=%h exp=%h", got, mkdata(gen, 29'h105)); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL miss_pulses got=%0d exp=1", pulses); end
        checks++; if (lat !== 3 + 1 + NBEAT + 1) begin failures++; $display("FAIL miss_latency got=%0d exp=%0d", lat, 5 + NBEAT); end
        checks++; if (busy_hold !== 1'b1) begin failures++; $display("FAIL miss_busy_held got=%b exp=1", busy_hold); end
        checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL miss_busy_release got=%b exp=0", busy_after); end
        g_save = gen;
    endtask

`ifdef PGM_DDRAM_CACHE_EN
    task automatic test_hit();
        run_read(29'h107, 0, 0, -1, rd_cyc, s_addr, s_cnt, got, pulses, lat, busy_hold, busy_after, tmo);
        checks++; if (rd_cyc !== 0) begin failures++; $display("FAIL hit_rd_cycles got=%0d exp=0", rd_cyc); end
        checks++; if (got !== mkdata(g_save, 29'h107)) begin failures++; $display("FAIL hit_data got=%h exp=%h", got, mkdata(g_save, 29'h107)); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL hit_latency got=%0d exp=2", lat); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL hit_pulses got=%0d exp=1", pulses); end
        run_read(29'h108, 0, 0, -1, rd_cyc, s_addr, s_cnt, got, pulses, lat, busy_hold, busy_after, tmo);
        checks++; if (rd_cyc !== 1) begin failures++; $display("FAIL next_line_rd got=%0d exp=1", rd_cyc); end
        checks++; if (s_addr !== 29'h108) begin failures++; $display("FAIL next_line_addr got=%h exp=108", s_addr); end
        checks++; if (got !== mkdata(gen, 29'h108)) begin failures++; $display("FAIL next_line_data got=%h exp=%h", got, mkdata(gen, 29'h108)); end
    endtask
`endif

    task automatic test_held_rd();
        run_read(29'h105, 0, 1, -1, rd_cyc, s_addr, s_cnt, got, pulses, lat, busy_hold, busy_after, tmo);
        g_save = gen;
        checks++; if (pulses !== 1) begin failures++; $display("FAIL held_pulses got=%0d exp=1", pulses); end
        checks++; if (rd_cyc !== 1) begin failures++; $display("FAIL held_rd_cycles got=%0d exp=1", rd_cyc); end
        checks++; if (busy_hold !== 1'b1) begin failures++; $display("FAIL held_busy got=%b exp=1", busy_hold); end
        checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL held_release got=%b exp=0", busy_after); end
`ifdef PGM_DDRAM_CACHE_EN
        run_read(29'h106, 0, 0, -1, rd_cyc, s_addr, s_cnt, got, pulses, lat, busy_hold, busy_after, tmo);
        checks++; if (rd_cyc !== 0) begin failures++; $display("FAIL held_hit_rd got=%0d exp=0", rd_cyc); end
        checks++; if (got !== mkdata(g_save, 29'h106)) begin failures++; $display("FAIL held_hit_data got=%h exp=%h", got, mkdata(g_save, 29'h106)); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL held_hit_pulses got=%0d exp=1", pulses); end
`endif
    endtask

    task automatic test_inval();
        inval = 1'b1;
        @(posedge clk); #1;
        inval = 1'b0;
        run_read(29'h106, 0, 0, -1, rd_cyc, s_addr, s_cnt, got, pulses, lat, busy_hold, busy_after, tmo);
        checks++; if (rd_cyc !== 1) begin failures++; $display("FAIL inval_idle_rd got=%0d exp=1", rd_cyc); end
        checks++; if (s_addr !== line_base(29'h106)) begin failures++; $display("FAIL inval_idle_addr got=%h exp=%h", s_addr, line_base(29'h106)); end
        run_read(29'h10C, 0, 0, 0, rd_cyc, s_addr, s_cnt, got, pulses, lat, busy_hold, busy_after, tmo);
        checks++; if (got !== mkdata(gen, 29'h10C)) begin failures++; $display("FAIL inval_fill_data got=%h exp=%h", got, mkdata(gen, 29'h10C)); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL inval_fill_pulses got=%0d exp=1", pulses); end
        run_read(29'h10D, 0, 0, -1, rd_cyc, s_addr, s_cnt, got, pulses, lat, busy_hold, busy_after, tmo);
        checks++; if (rd_cyc !== 1) begin failures++; $display("FAIL inval_refetch_rd got=%0d exp=1", rd_cyc); end
        checks++; if (got !== mkdata(gen, 29'h10D)) begin failures++; $display("FAIL inval_refetch_data got=%h exp=%h", got, mkdata(gen, 29'h10D)); end
`ifdef PGM_DDRAM_CACHE_EN
        run_read(29'h110, 0, 0, 3, rd_cyc, s_addr, s_cnt, got, pulses, lat, busy_hold, busy_after, tmo);
        checks++; if (got !== mkdata(gen, 29'h110)) begin failures++; $display("FAIL inval_last_data got=%h exp=%h", got, mkdata(gen, 29'h110)); end
        run_read(29'h111, 0, 0, -1, rd_cyc, s_addr, s_cnt, got, pulses, lat, busy_hold, busy_after, tmo);
        g_save = gen;
        checks++; if (rd_cyc !== 1) begin failures++; $display("FAIL inval_last_refetch got=%0d exp=1", rd_cyc); end
        run_read(29'h112, 0, 0, -1, rd_cyc, s_addr, s_cnt, got, pulses, lat, busy_hold, busy_after, tmo);
        checks++; if (rd_cyc !== 0) begin failures++; $display("FAIL refill_hit_rd got=%0d exp=0", rd_cyc); end
        checks++; if (got !== mkdata(g_save, 29'h112)) begin failures++; $display("FAIL refill_hit_data got=%h exp=%h", got, mkdata(g_save, 29'h112)); end
`endif
    endtask

    task automatic test_reset_mid_burst();
        bit seen = 0;
        bit stray_ready = 0;
        gen++;
        vid_addr = 29'h120;
        vid_rd   = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            seen = DDRAM_RD;
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL rstmid_request got=%b exp=1", seen); end
        for (int b = 0; b < (CACHE ? 2 : 0); b++) begin
            @(posedge clk); #1;
            DDRAM_DOUT_READY = 1'b1;
            DDRAM_DOUT = mkdata(gen, 29'h120 + 29'(b));
        end
        @(posedge clk); #1;
        DDRAM_DOUT_READY = 1'b0;
        reset  = 1'b0;
        vid_rd = 1'b0;
        @(posedge clk); #1;
        checks++; if (vid_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", vid_busy); end
        checks++; if (vid_dout_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b exp=0", vid_dout_ready); end
        checks++; if (vid_dout !== 64'd0) begin failures++; $display("FAIL rstmid_dout got=%h exp=0", vid_dout); end
        checks++; if (DDRAM_RD !== 1'b0) begin failures++; $display("FAIL rstmid_rd got=%b exp=0", DDRAM_RD); end
        checks++; if (DDRAM_ADDR !== 29'd0) begin failures++; $display("FAIL rstmid_addr got=%h exp=0", DDRAM_ADDR); end
        checks++; if (DDRAM_BURSTCNT !== 8'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=0", DDRAM_BURSTCNT); end
        reset = 1'b1;
        // Leftover beats arriving while idle must be dropped.
        for (int b = 0; b < 3; b++) begin
            DDRAM_DOUT_READY = (b < 2);
            DDRAM_DOUT = mkdata(gen, 29'h122 + 29'(b));
            @(posedge clk); #1;
            if (vid_dout_ready) stray_ready = 1;
        end
        DDRAM_DOUT_READY = 1'b0;
        checks++; if (stray_ready !== 1'b0) begin failures++; $display("FAIL stray_ready got=%b exp=0", stray_ready); end
        checks++; if (vid_dout !== 64'd0) begin failures++; $display("FAIL stray_dout got=%h exp=0", vid_dout); end
        run_read(29'h121, 0, 0, -1, rd_cyc, s_addr, s_cnt, got, pulses, lat, busy_hold, busy_after, tmo);
        checks++; if (rd_cyc !== 1) begin failures++; $display("FAIL post_reset_rd got=%0d exp=1", rd_cyc); end
        checks++; if (s_addr !== line_base(29'h121)) begin failures++; $display("FAIL post_reset_addr got=%h exp=%h", s_addr, line_base(29'h121)); end
        checks++; if (got !== mkdata(gen, 29'h121)) begin failures++; $display("FAIL post_reset_data got=%h exp=%h", got, mkdata(gen, 29'h121)); end
    endtask

    initial begin
        test_reset();
        test_miss();
`ifdef PGM_DDRAM_CACHE_EN
        test_hit();
`endif
        test_held_rd();
        test_inval();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
